// File: rtl/spu_pkg.sv
// ============================================================================
//  Module   : spu_pkg
//  Purpose  : Shared types and constants for the SPU general register file.
//             Provides the address and quadword types, plus the writeback
//             triple struct that the even and odd execution pipes produce.
//  Contents : NUM_REGS, WIDTH, ADDR_W constants
//             reg_addr_t, quadword_t, writeback_t types
//             wb_hits() helper (writeback targets a given address)
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package spu_pkg;

  localparam int NUM_REGS = 128;
  localparam int WIDTH    = 128;
  localparam int ADDR_W   = 7;

  // Big-endian bit numbering matches the SPU architecture documents.
  typedef logic [0:ADDR_W-1] reg_addr_t;
  typedef logic [0:WIDTH-1]  quadword_t;

  typedef struct packed {
    quadword_t rt;
    reg_addr_t addr;
    logic      we;
  } writeback_t;

  // True when the writeback is live and targets the given register.
  function automatic logic wb_hits(input writeback_t wb, input reg_addr_t addr);
    return wb.we && (wb.addr == addr);
  endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_read_port.sv
// ============================================================================
//  Module   : regfile_read_port
//  Purpose  : Next-value select for one register-file read port.
//             With REGFILE_BYPASS_EN defined, a same-cycle writeback to the
//             address being read is forwarded (odd pipe over even pipe over
//             stored entry). Without it the stored entry is returned and any
//             forwarding is left to the FWD stage.
//  Ports    : addr       - register address being read
//             stored     - current contents of mem[addr]
//             wb_even    - even-pipe writeback triple
//             wb_odd     - odd-pipe writeback triple
//             next_value - value to load into the output register
//  Macros   : REGFILE_BYPASS_EN - enables write-to-read bypass
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module regfile_read_port
  import spu_pkg::*;
(
  input  reg_addr_t  addr,
  input  quadword_t  stored,
  input  writeback_t wb_even,
  input  writeback_t wb_odd,
  output quadword_t  next_value
);

`ifdef REGFILE_BYPASS_EN
  // Odd pipe is later in program order, so it wins a collision just as it
  // does in the array itself.
  always_comb begin
    next_value = stored;
    if (wb_hits(wb_odd, addr)) begin
      next_value = wb_odd.rt;
    end else if (wb_hits(wb_even, addr)) begin
      next_value = wb_even.rt;
    end
  end
`else
  assign next_value = stored;

  // Writeback triples only matter for the bypass build.
  logic w_unused_bypass;
  assign w_unused_bypass = ^{addr, wb_even, wb_odd};
`endif

endmodule

`default_nettype wire

// File: rtl/register_file.sv
// ============================================================================
//  Module   : register_file
//  Purpose  : 128 x 128-bit SPU general register file in the RF/FWD stage.
//             Two writeback ports (even and odd pipe) and three registered
//             read ports (ra, rb, rc) with one-cycle latency.
//  Ports    : clk, reset                   - clock, synchronous active-high reset
//             read_en                      - capture new operands when 1
//             ra_addr, rb_addr, rc_addr    - source register addresses
//             ra, rb, rc                   - registered operand values
//             rt_even_wb, rt_addr_even_wb,
//             reg_write_even_wb            - even-pipe writeback triple
//             rt_odd_wb, rt_addr_odd_wb,
//             reg_write_odd_wb             - odd-pipe writeback triple
//  Macros   : REGFILE_BYPASS_EN - same-cycle write-to-read bypass
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module register_file
  import spu_pkg::*;
#(
  parameter int NUM_REGS = spu_pkg::NUM_REGS,
  parameter int WIDTH    = spu_pkg::WIDTH,
  parameter int ADDR_W   = spu_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              read_en,
  input  logic [0:ADDR_W-1] ra_addr,
  input  logic [0:ADDR_W-1] rb_addr,
  input  logic [0:ADDR_W-1] rc_addr,
  output logic [0:WIDTH-1]  ra,
  output logic [0:WIDTH-1]  rb,
  output logic [0:WIDTH-1]  rc,
  input  logic [0:WIDTH-1]  rt_even_wb,
  input  logic [0:ADDR_W-1] rt_addr_even_wb,
  input  logic              reg_write_even_wb,
  input  logic [0:WIDTH-1]  rt_odd_wb,
  input  logic [0:ADDR_W-1] rt_addr_odd_wb,
  input  logic              reg_write_odd_wb
);

  localparam int NUM_RD = 3;

  // --------------------------------------------------------------------------
  // Writeback triples
  // --------------------------------------------------------------------------
  writeback_t w_wb_even;
  writeback_t w_wb_odd;

  assign w_wb_even = '{rt: rt_even_wb, addr: rt_addr_even_wb, we: reg_write_even_wb};
  assign w_wb_odd  = '{rt: rt_odd_wb,  addr: rt_addr_odd_wb,  we: reg_write_odd_wb};

  // --------------------------------------------------------------------------
  // Storage array
  // --------------------------------------------------------------------------
  quadword_t r_mem [NUM_REGS];

  // The odd write is issued after the even write so that on an address
  // collision the odd-pipe value is the one that lands.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_wb_even.we) begin
        r_mem[w_wb_even.addr] <= w_wb_even.rt;
      end
      if (w_wb_odd.we) begin
        r_mem[w_wb_odd.addr] <= w_wb_odd.rt;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Read ports
  // --------------------------------------------------------------------------
  reg_addr_t w_rd_addr [NUM_RD];
  quadword_t w_rd_next [NUM_RD];
  quadword_t r_rd      [NUM_RD];

  assign w_rd_addr[0] = ra_addr;
  assign w_rd_addr[1] = rb_addr;
  assign w_rd_addr[2] = rc_addr;

  for (genvar g = 0; g < NUM_RD; g++) begin : g_read_port
    regfile_read_port u_read_port (
      .addr       (w_rd_addr[g]),
      .stored     (r_mem[w_rd_addr[g]]),
      .wb_even    (w_wb_even),
      .wb_odd     (w_wb_odd),
      .next_value (w_rd_next[g])
    );

    // Operand registers hold while read_en is low; reset discards any read.
    always_ff @(posedge clk) begin
      if (reset) begin
        r_rd[g] <= '0;
      end else if (read_en) begin
        r_rd[g] <= w_rd_next[g];
      end
    end
  end

  assign ra = r_rd[0];
  assign rb = r_rd[1];
  assign rc = r_rd[2];

endmodule

`default_nettype wire

// File: doc/register_file.md
Name: register_file

Overview:
- 128-entry × 128-bit SPU general register file.
- Sits in the RF/FWD stage, directly upstream of the execution units (Byte, even/odd pipes).
- Supplies the ra/rb/rc operand values those units consume.
- Accepts the even- and odd-pipe writeback triples (rt_wb, rt_addr_wb, reg_write_wb) those units produce.
- Registered reads with optional same-cycle write-to-read bypass.

Parameters:
- NUM_REGS, 128, number of architectural registers
- WIDTH, 128, register width in bits (big-endian [0:WIDTH-1])
- ADDR_W, 7, register address width

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- read_en  input  1  1 = capture new operands this cycle; 0 = hold ra/rb/rc
- ra_addr  input  7  source register A address
- rb_addr  input  7  source register B address
- rc_addr  input  7  source register C address (RRR format)
- ra  output  128  register A value
- rb  output  128  register B value
- rc  output  128  register C value
- rt_even_wb  input  128  even-pipe writeback value
- rt_addr_even_wb  input  7  even-pipe destination
- reg_write_even_wb  input  1  even-pipe write enable
- rt_odd_wb  input  128  odd-pipe writeback value
- rt_addr_odd_wb  input  7  odd-pipe destination
- reg_write_odd_wb  input  1  odd-pipe write enable

Behaviour:
- Reset (reset=1 at posedge):
  - All NUM_REGS entries become 0.
  - ra, rb and rc become 0.
  - Writes and reads presented in that cycle are discarded.
- Writes: at posedge, if reg_write_even_wb=1, then mem[rt_addr_even_wb] <= rt_even_wb. The odd pipe behaves the same way.
- Write collision: both enables high with equal addresses → odd-pipe value is stored. The odd instruction is later in program order.
- Reads are synchronous with 1-cycle latency. If read_en=1 at posedge N, ra/rb/rc show the addressed values after edge N and hold until the next edge with read_en=1.
- read_en=0: outputs hold their previous values; writes still proceed.
- Read value selection, per port, in priority order:
  - odd write to the same address this cycle;
  - else even write to the same address this cycle;
  - else stored entry.
  - This write-to-read bypass applies only with the optional feature enabled.
- Any port may read any address. All three ports may read the same address.
- Addresses are always in range (7 bits, 128 entries); there is no wrap-around logic.
- Writes with enable=0 are ignored regardless of address or data. This includes the NOP triple (0, 0, 0) the execution units emit.
- Outputs are pure registers; there are no combinational paths from inputs to outputs.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: a same-cycle write to an address being read appears on the read output after that edge, using the collision priority above.
- Undefined: the read returns the pre-write stored value. The new value is visible on the next read of that address. Forwarding is then the FWD stage's responsibility.

Decomposition:
- Shared package spu_pkg:
  - reg_addr_t = logic [0:6]
  - quadword_t = logic [0:127]
  - NUM_REGS constant
  - writeback struct {quadword_t rt; reg_addr_t addr; logic we;} for the even/odd triples
- One natural sub-module: regfile_read_port, instantiated three times. It takes the address, the stored entry and both writeback triples, and produces the next output value including the bypass mux.

Test Plan:
- Reset: hold reset 1 cycle, then read r0, r64 and r127 → all 0 one cycle later.
- Basic write/read: even write r5=0x0123…EF; next cycle read ra_addr=5 → ra=0x0123…EF one cycle after the read.
- Collision: even and odd both write r10 (0xAA…, 0xBB…) in one cycle; then read r10 → 0xBB….
- Bypass: write r7=0x55… and read rb_addr=7 in the same cycle → rb=0x55… with REGFILE_BYPASS_EN defined, old value (0) without it.
- read_en=0 hold: load ra=r3, drop read_en, write r3=0xFF… → ra is unchanged until read_en=1 again.
- Mid-operation reset: write r9=0x11…, assert reset with simultaneous odd write r9=0x22… → r9 reads 0 after reset.
